ilkn_latency_run_ctrl: RTL and testbench
========================================

Name: ilkn_latency_run_ctrl

Overview:
Run sequencer for the driver/repeater Interlaken example-design pair. It supervises GT lock and RX alignment, then runs a programmable number of restart-triggered traffic bursts. For each burst it measures latency (restart pulse to combined rx_done) and accumulates last/min/max/sum statistics. It replaces the open-loop bring-up FSM with timeouts, fail detection and a per-run PM tick, and drives lbus_tx_rx_restart_in / s_axi_pm_tick on both exdes instances.

Parameters:
TIMEOUT_CYCLES, 20'hF_FFFF, per-state wait limit in init_clk cycles (min 4)
LAT_W, 24, latency counter/statistic width
RUNS_W, 8, run-count width
SUM_W, 32, latency accumulator width

Ports:
init_clk  in  1  sole clock
sys_reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; honoured only in IDLE, DONE or FAIL
num_runs  in  RUNS_W  bursts per test, sampled on start; 0 is treated as 1
rx_gt_locked  in  1  AND of drv/rpt gt_locked
rx_aligned  in  1  AND of drv/rpt aligned
tx_done, rx_done  in  1 each  AND of drv/rpt done
tx_busy, rx_busy  in  1 each  AND of drv/rpt busy
tx_fail, rx_failed  in  1 each  OR of drv/rpt fail
lbus_tx_rx_restart  out  1  restart pulse to both exdes
s_axi_pm_tick  out  1  one-cycle PM snapshot pulse
state_o  out  4  current state encoding
run_cnt  out  RUNS_W  completed runs
lat_last, lat_min, lat_max  out  LAT_W each  latency statistics (cycles)
lat_sum  out  SUM_W  sum of latencies, saturating
test_done  out  1  level, high in DONE
test_fail  out  1  level, high in FAIL
fail_code  out  3  0 none, 1 lock timeout, 2 align timeout, 3 drain timeout, 4 busy timeout, 5 send timeout, 6 recv timeout, 7 tx_fail/rx_failed

Behaviour:
- Reset, async assert and sync-safe release: state IDLE. All outputs 0 except lat_min = all-ones.
- States (encodings 0-10): IDLE, LOCK_WAIT, ALIGN_WAIT, DRAIN_WAIT, RESTART, BUSY_WAIT, SEND_WAIT, RECV_WAIT, NEXT, DONE, FAIL.
- IDLE/DONE/FAIL + start -> LOCK_WAIT. Clears run_cnt, lat_* (lat_min to all-ones), fail_code; latches num_runs.
- LOCK_WAIT: rx_gt_locked -> ALIGN_WAIT.
- ALIGN_WAIT: rx_aligned -> DRAIN_WAIT.
- DRAIN_WAIT: !tx_busy && !rx_busy -> RESTART. This drains auto-generated traffic and the previous burst.
- RESTART: lbus_tx_rx_restart = 1 for exactly this one cycle. Latency counter loads 0. Next state BUSY_WAIT.
- BUSY_WAIT: tx_busy && rx_busy -> SEND_WAIT.
- SEND_WAIT: tx_done -> RECV_WAIT.
- RECV_WAIT: first cycle rx_done = 1 -> lat_last <= counter. Update min/max/sum. Go to NEXT.
- Latency counter increments every cycle after RESTART through RECV_WAIT and saturates at all-ones. Example: rx_done seen 3 cycles after the restart cycle gives lat = 3.
- NEXT: s_axi_pm_tick = 1 for one cycle; run_cnt += 1. If run_cnt+1 == num_runs, go to DONE, else DRAIN_WAIT.
- Timeout counter clears on every state change. If a wait state (LOCK..RECV excluding RESTART) stays for TIMEOUT_CYCLES cycles, go to FAIL with the matching fail_code.
- tx_fail or rx_failed high in BUSY/SEND/RECV_WAIT -> FAIL, code 7. This has priority over the normal transition and over a timeout in the same cycle.
- rx_gt_locked or rx_aligned dropping after ALIGN_WAIT -> FAIL with code 1 or 2 respectively.
- The same-cycle min/max update on the first run gives min = max = lat_last.
- lat_sum saturates at all-ones and does not wrap.
- start in any non-idle state is ignored. sys_reset mid-run aborts immediately to reset values, and the restart pulse never stretches.
- Outputs are registered; state_o and test_done/test_fail reflect the state register.

Decomposition:
- Package ilkn_ctrl_pkg holds:
  - state encodings;
  - fail_code constants;
  - default TIMEOUT_CYCLES.
- One sub-module, ilkn_lat_stats: takes latency value plus a capture strobe and owns last/min/max/saturating-sum registers with clear. The FSM, timeout and latency counter stay in the top.

Test Plan:
- Nominal: num_runs=3; lock at cycle 10, align at 20; each burst has tx_done 40 and rx_done 50 cycles after restart -> exactly 3 restart pulses, 3 pm ticks, run_cnt=3, lat_last=lat_min=lat_max=50, lat_sum=150, test_done=1.
- Varying latency: rx_done at 30, 70, 45 cycles -> lat_min=30, lat_max=70, lat_sum=145, lat_last=45.
- Timeout: TIMEOUT_CYCLES=100, rx_aligned never asserts -> FAIL exactly 100 cycles after entering ALIGN_WAIT, fail_code=2, no restart pulse.
- Fail priority: rx_failed and rx_done high in the same RECV_WAIT cycle -> FAIL, fail_code=7, run_cnt unchanged, no pm tick.
- num_runs=0 -> exactly one run, then DONE. start pulse during SEND_WAIT -> ignored, no counters cleared.
- Async reset asserted in RESTART cycle -> restart output low within the same cycle, all stats at reset values. A subsequent start re-runs cleanly.

Source files
------------

// File: rtl/ilkn_ctrl_pkg.sv
// Shared state encodings, fail codes and defaults for the Interlaken run sequencer.
package ilkn_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOCK_WAIT  = 4'd1,
        S_ALIGN_WAIT = 4'd2,
        S_DRAIN_WAIT = 4'd3,
        S_RESTART    = 4'd4,
        S_BUSY_WAIT  = 4'd5,
        S_SEND_WAIT  = 4'd6,
        S_RECV_WAIT  = 4'd7,
        S_NEXT       = 4'd8,
        S_DONE       = 4'd9,
        S_FAIL       = 4'd10
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_LOCK_TO  = 3'd1;
    localparam logic [2:0] FC_ALIGN_TO = 3'd2;
    localparam logic [2:0] FC_DRAIN_TO = 3'd3;
    localparam logic [2:0] FC_BUSY_TO  = 3'd4;
    localparam logic [2:0] FC_SEND_TO  = 3'd5;
    localparam logic [2:0] FC_RECV_TO  = 3'd6;
    localparam logic [2:0] FC_TRAFFIC  = 3'd7;

    localparam int unsigned TIMEOUT_DEFAULT = 32'h000F_FFFF;

    // Non-zero only for states that are guarded by the timeout counter.
    function automatic logic [2:0] timeout_code(input state_t s);
        case (s)
            S_LOCK_WAIT:  timeout_code = FC_LOCK_TO;
            S_ALIGN_WAIT: timeout_code = FC_ALIGN_TO;
            S_DRAIN_WAIT: timeout_code = FC_DRAIN_TO;
            S_BUSY_WAIT:  timeout_code = FC_BUSY_TO;
            S_SEND_WAIT:  timeout_code = FC_SEND_TO;
            S_RECV_WAIT:  timeout_code = FC_RECV_TO;
            default:      timeout_code = FC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ilkn_lat_stats.sv
// Burst latency statistics: last/min/max and a saturating sum, cleared at test start.
module ilkn_lat_stats #(
    parameter int LAT_W = 24,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic [SUM_W-1:0] lat_sum
);

    logic [SUM_W:0] sum_ext;

    assign sum_ext = {1'b0, lat_sum} + (SUM_W+1)'(lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
            lat_sum  <= '0;
        end else if (clr) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
            lat_sum  <= '0;
        end else if (cap) begin
            lat_last <= lat;
            if (lat < lat_min) lat_min <= lat;
            if (lat > lat_max) lat_max <= lat;
            lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        end
    end

endmodule

// File: rtl/ilkn_latency_run_ctrl.sv
// Run sequencer for the Interlaken driver/repeater pair: link bring-up supervision,
// restart-triggered bursts with per-burst latency measurement and a PM tick per run.
module ilkn_latency_run_ctrl
    import ilkn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int          LAT_W          = 24,
    parameter int          RUNS_W         = 8,
    parameter int          SUM_W          = 32
) (
    input  logic              init_clk,
    input  logic              sys_reset,
    input  logic              start,
    input  logic [RUNS_W-1:0] num_runs,
    input  logic              rx_gt_locked,
    input  logic              rx_aligned,
    input  logic              tx_done,
    input  logic              rx_done,
    input  logic              tx_busy,
    input  logic              rx_busy,
    input  logic              tx_fail,
    input  logic              rx_failed,
    output logic              lbus_tx_rx_restart,
    output logic              s_axi_pm_tick,
    output logic [3:0]        state_o,
    output logic [RUNS_W-1:0] run_cnt,
    output logic [LAT_W-1:0]  lat_last,
    output logic [LAT_W-1:0]  lat_min,
    output logic [LAT_W-1:0]  lat_max,
    output logic [SUM_W-1:0]  lat_sum,
    output logic              test_done,
    output logic              test_fail,
    output logic [2:0]        fail_code
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state, next_state;
    logic [2:0]        next_code;
    logic [TO_W-1:0]   to_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [RUNS_W-1:0] runs_target;
    logic              rst_meta, rst_int;
    logic              start_ok, timed_out, traffic_fail, link_watch, lat_cap;

    // Reset asserts immediately but releases two clocks later, in step with init_clk.
    always_ff @(posedge init_clk or posedge sys_reset) begin
        if (sys_reset) {rst_int, rst_meta} <= 2'b11;
        else           {rst_int, rst_meta} <= {rst_meta, 1'b0};
    end

    assign start_ok     = start && (state inside {S_IDLE, S_DONE, S_FAIL});
    assign timed_out    = (timeout_code(state) != FC_NONE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign traffic_fail = (tx_fail || rx_failed) && (state inside {S_BUSY_WAIT, S_SEND_WAIT, S_RECV_WAIT});
    assign link_watch   = state inside {S_DRAIN_WAIT, S_RESTART, S_BUSY_WAIT, S_SEND_WAIT, S_RECV_WAIT, S_NEXT};
    assign lat_cap      = (state == S_RECV_WAIT) && (next_state == S_NEXT);
    assign state_o      = state;

    always_comb begin
        next_state = state;
        next_code  = FC_NONE;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) next_state = S_LOCK_WAIT;
            S_LOCK_WAIT:  if (rx_gt_locked) next_state = S_ALIGN_WAIT;
            S_ALIGN_WAIT: if (rx_aligned) next_state = S_DRAIN_WAIT;
            S_DRAIN_WAIT: if (!tx_busy && !rx_busy) next_state = S_RESTART;
            S_RESTART:    next_state = S_BUSY_WAIT;
            S_BUSY_WAIT:  if (tx_busy && rx_busy) next_state = S_SEND_WAIT;
            S_SEND_WAIT:  if (tx_done) next_state = S_RECV_WAIT;
            S_RECV_WAIT:  if (rx_done) next_state = S_NEXT;
            S_NEXT:       next_state = (run_cnt + RUNS_W'(1) == runs_target) ? S_DONE : S_DRAIN_WAIT;
            default:      next_state = S_IDLE;
        endcase
        // Overrides in rising priority: timeout, link loss, traffic failure.
        if (timed_out && next_state == state) begin
            next_state = S_FAIL;
            next_code  = timeout_code(state);
        end
        if (link_watch && !rx_gt_locked) begin
            next_state = S_FAIL;
            next_code  = FC_LOCK_TO;
        end else if (link_watch && !rx_aligned) begin
            next_state = S_FAIL;
            next_code  = FC_ALIGN_TO;
        end
        if (traffic_fail) begin
            next_state = S_FAIL;
            next_code  = FC_TRAFFIC;
        end
    end

    always_ff @(posedge init_clk or posedge rst_int) begin
        if (rst_int) begin
            state              <= S_IDLE;
            lbus_tx_rx_restart <= 1'b0;
            s_axi_pm_tick      <= 1'b0;
            test_done          <= 1'b0;
            test_fail          <= 1'b0;
            fail_code          <= FC_NONE;
            run_cnt            <= '0;
            runs_target        <= RUNS_W'(1);
            to_cnt             <= '0;
            lat_cnt            <= '0;
        end else begin
            state              <= next_state;
            lbus_tx_rx_restart <= (next_state == S_RESTART);
            s_axi_pm_tick      <= (next_state == S_NEXT);
            test_done          <= (next_state == S_DONE);
            test_fail          <= (next_state == S_FAIL);

            if (start_ok) begin
                run_cnt     <= '0;
                fail_code   <= FC_NONE;
                runs_target <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
            end else begin
                if (state == S_NEXT) run_cnt <= run_cnt + RUNS_W'(1);
                if (next_state == S_FAIL && state != S_FAIL) fail_code <= next_code;
            end

            if (next_state != state || timeout_code(state) == FC_NONE) to_cnt <= '0;
            else                                                         to_cnt <= to_cnt + TO_W'(1);

            // Counter reads 0 during the restart cycle and k on the k-th cycle after it.
            if (next_state == S_RESTART)
                lat_cnt <= '0;
            else if ((state inside {S_RESTART, S_BUSY_WAIT, S_SEND_WAIT, S_RECV_WAIT}) && lat_cnt != '1)
                lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    ilkn_lat_stats #(
        .LAT_W (LAT_W),
        .SUM_W (SUM_W)
    ) u_stats (
        .clk      (init_clk),
        .rst      (rst_int),
        .clr      (start_ok),
        .cap      (lat_cap),
        .lat      (lat_cnt),
        .lat_last (lat_last),
        .lat_min  (lat_min),
        .lat_max  (lat_max),
        .lat_sum  (lat_sum)
    );

endmodule

// File: tb/tb_ilkn_latency_run_ctrl.sv
// Bench for ilkn_latency_run_ctrl: behavioural exdes pair plus a latency scoreboard.
module tb_ilkn_latency_run_ctrl;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ALIGN  = 4'd2;
    localparam logic [3:0] ST_SEND   = 4'd6;
    localparam logic [3:0] ST_DONE   = 4'd9;
    localparam logic [3:0] ST_FAIL   = 4'd10;
    localparam logic [23:0] LAT_ONES = 24'hFF_FFFF;

    logic        init_clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_runs = '0;
    logic        rx_gt_locked = 1'b0, rx_aligned = 1'b0;
    logic        tx_done = 1'b0, rx_done = 1'b0;
    logic        tx_busy = 1'b0, rx_busy = 1'b0;
    logic        tx_fail = 1'b0, rx_failed = 1'b0;
    logic        lbus_tx_rx_restart, s_axi_pm_tick, test_done, test_fail;
    logic [3:0]  state_o;
    logic [7:0]  run_cnt;
    logic [23:0] lat_last, lat_min, lat_max;
    logic [31:0] lat_sum;
    logic [2:0]  fail_code;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_restart, n_tick, burst, cur_lat, cur_idx, k, fail_burst;
    bit active = 0;
    int lat_tab [0:7];
    int exp_q [$];
    int t_a;

    ilkn_latency_run_ctrl #(
        .TIMEOUT_CYCLES (100),
        .LAT_W          (24),
        .RUNS_W         (8),
        .SUM_W          (32)
    ) dut (
        .init_clk           (init_clk),
        .sys_reset          (sys_reset),
        .start              (start),
        .num_runs           (num_runs),
        .rx_gt_locked       (rx_gt_locked),
        .rx_aligned         (rx_aligned),
        .tx_done            (tx_done),
        .rx_done            (rx_done),
        .tx_busy            (tx_busy),
        .rx_busy            (rx_busy),
        .tx_fail            (tx_fail),
        .rx_failed          (rx_failed),
        .lbus_tx_rx_restart (lbus_tx_rx_restart),
        .s_axi_pm_tick      (s_axi_pm_tick),
        .state_o            (state_o),
        .run_cnt            (run_cnt),
        .lat_last           (lat_last),
        .lat_min            (lat_min),
        .lat_max            (lat_max),
        .lat_sum            (lat_sum),
        .test_done          (test_done),
        .test_fail          (test_fail),
        .fail_code          (fail_code)
    );

    always #5 init_clk = ~init_clk;
    always @(posedge init_clk) cyc++;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
        int i = 0;
        while (state_o !== s && i < budget) begin
            @(negedge init_clk);
            i++;
        end
        check_val(tag, state_o, s);
    endtask

    task automatic start_run(input logic [7:0] n);
        burst = 0; n_restart = 0; n_tick = 0;
        exp_q.delete();
        active = 1;
        start = 1'b1; num_runs = n;
        @(negedge init_clk);
        start = 1'b0;
    endtask

    // Exdes pair: busy from k=2, tx_done at lat-10, rx_done and busy drop at lat.
    initial begin
        forever begin
            @(negedge init_clk);
            if (active) begin
                if (lbus_tx_rx_restart) begin
                    n_restart++;
                    k = 0;
                    cur_idx = burst;
                    cur_lat = lat_tab[burst];
                    burst++;
                    exp_q.push_back(cur_lat);
                    tx_busy = 0; rx_busy = 0; tx_done = 0; rx_done = 0; rx_failed = 0;
                end else begin
                    k++;
                    tx_busy   = (k >= 2 && k < cur_lat);
                    rx_busy   = tx_busy;
                    tx_done   = (k >= cur_lat - 10);
                    rx_done   = (k >= cur_lat);
                    rx_failed = (cur_idx == fail_burst && k >= cur_lat);
                end
                if (s_axi_pm_tick) begin
                    n_tick++;
                    if (exp_q.size() == 0) check_val("sb_underflow", 0, 1);
                    else check_val("sb_lat_last", lat_last, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        fail_burst = -1;
        cur_idx = -1;
        cur_lat = 0;
        k = 0;
        repeat (3) @(negedge init_clk);
        check_val("rst_state", state_o, ST_IDLE);
        check_val("rst_lat_min", lat_min, LAT_ONES);
        check_val("rst_restart", lbus_tx_rx_restart, 0);
        check_val("rst_fail_code", fail_code, 0);
        sys_reset = 1'b0;
        repeat (5) @(negedge init_clk);
        check_val("rst_idle_after", state_o, ST_IDLE);

        // Nominal: 3 bursts of latency 50, link comes up at +10/+20
        lat_tab = '{50, 50, 50, 0, 0, 0, 0, 0};
        start_run(8'd3);
        repeat (9) @(negedge init_clk);
        rx_gt_locked = 1'b1;
        repeat (10) @(negedge init_clk);
        rx_aligned = 1'b1;
        wait_state("nom_done", ST_DONE, 1000);
        check_val("nom_restarts", n_restart, 3);
        check_val("nom_ticks", n_tick, 3);
        check_val("nom_run_cnt", run_cnt, 3);
        check_val("nom_lat_last", lat_last, 50);
        check_val("nom_lat_min", lat_min, 50);
        check_val("nom_lat_max", lat_max, 50);
        check_val("nom_lat_sum", lat_sum, 150);
        check_val("nom_test_done", test_done, 1);
        check_val("nom_fail_code", fail_code, 0);

        // Varying latency, with a start pulse during SEND_WAIT of burst 2
        lat_tab = '{30, 70, 45, 0, 0, 0, 0, 0};
        start_run(8'd3);
        check_val("var_clr_sum", lat_sum, 0);
        check_val("var_clr_min", lat_min, LAT_ONES);
        check_val("var_clr_run", run_cnt, 0);
        begin
            int i = 0;
            while (!(n_tick == 1 && state_o == ST_SEND) && i < 1000) begin
                @(negedge init_clk);
                i++;
            end
        end
        check_val("ign_reach_send", state_o, ST_SEND);
        start = 1'b1; num_runs = 8'd1;
        @(negedge init_clk);
        start = 1'b0;
        check_val("ign_state", state_o, ST_SEND);
        check_val("ign_run_cnt", run_cnt, 1);
        check_val("ign_lat_last", lat_last, 30);
        wait_state("var_done", ST_DONE, 1000);
        check_val("var_run_cnt", run_cnt, 3);
        check_val("var_lat_min", lat_min, 30);
        check_val("var_lat_max", lat_max, 70);
        check_val("var_lat_sum", lat_sum, 145);
        check_val("var_lat_last", lat_last, 45);

        // num_runs = 0 behaves as a single run
        lat_tab = '{20, 20, 20, 20, 0, 0, 0, 0};
        start_run(8'd0);
        wait_state("one_done", ST_DONE, 1000);
        repeat (5) @(negedge init_clk);
        check_val("one_restarts", n_restart, 1);
        check_val("one_run_cnt", run_cnt, 1);
        check_val("one_lat_sum", lat_sum, 20);

        // Align never comes: FAIL exactly 100 cycles after entering ALIGN_WAIT
        rx_gt_locked = 1'b0; rx_aligned = 1'b0;
        start_run(8'd2);
        repeat (9) @(negedge init_clk);
        rx_gt_locked = 1'b1;
        wait_state("to_align", ST_ALIGN, 50);
        t_a = cyc;
        wait_state("to_fail", ST_FAIL, 300);
        check_val("to_delay", cyc - t_a, 100);
        check_val("to_code", fail_code, 2);
        check_val("to_test_fail", test_fail, 1);
        check_val("to_restarts", n_restart, 0);

        // rx_failed coincides with rx_done on burst 2
        rx_aligned = 1'b1;
        lat_tab = '{35, 40, 0, 0, 0, 0, 0, 0};
        fail_burst = 1;
        start_run(8'd2);
        wait_state("fp_fail", ST_FAIL, 1000);
        check_val("fp_code", fail_code, 7);
        check_val("fp_run_cnt", run_cnt, 1);
        check_val("fp_ticks", n_tick, 1);
        check_val("fp_lat_last", lat_last, 35);
        check_val("fp_sb_left", exp_q.size(), 1);
        fail_burst = -1;
        rx_failed = 1'b0;

        // Async reset in the restart cycle of burst 2, then a clean rerun
        lat_tab = '{25, 25, 0, 0, 0, 0, 0, 0};
        start_run(8'd2);
        begin
            int i = 0;
            while (!(lbus_tx_rx_restart && burst == 2) && i < 1000) begin
                @(negedge init_clk);
                #1;
                i++;
            end
        end
        check_val("ar_seen", burst, 2);
        check_val("ar_pre_run", run_cnt, 1);
        sys_reset = 1'b1;
        #1;
        check_val("ar_restart", lbus_tx_rx_restart, 0);
        check_val("ar_state", state_o, ST_IDLE);
        check_val("ar_run_cnt", run_cnt, 0);
        check_val("ar_lat_last", lat_last, 0);
        check_val("ar_lat_min", lat_min, LAT_ONES);
        check_val("ar_lat_sum", lat_sum, 0);
        active = 0;
        tx_busy = 0; rx_busy = 0; tx_done = 0; rx_done = 0;
        repeat (3) @(negedge init_clk);
        sys_reset = 1'b0;
        repeat (5) @(negedge init_clk);
        check_val("ar_idle", state_o, ST_IDLE);
        lat_tab = '{22, 0, 0, 0, 0, 0, 0, 0};
        start_run(8'd1);
        wait_state("ar_rerun_done", ST_DONE, 1000);
        check_val("ar_rerun_restarts", n_restart, 1);
        check_val("ar_rerun_run_cnt", run_cnt, 1);
        check_val("ar_rerun_lat", lat_last, 22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
